pipelined_addsub: RTL and testbench

//  Parametrised, pipelined two's-complement adder/subtractor for the datapath adder family.

---
 rtl/adder_pkg.sv | 15 +
 rtl/addsub_stage.sv | 64 ++++++
 rtl/pipelined_addsub.sv | 76 +++++++
 tb/tb_pipelined_addsub.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - op encodings and parameter helpers for the pipelined adder/subtractor
package adder_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   function automatic bit params_ok(input int width, input int stages);
      return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
   endfunction

   function automatic int chunk_width(input int width, input int stages);
      return (stages > 0) ? (width / stages) : width;
   endfunction

endpackage

// File: rtl/addsub_stage.sv
// rtl/addsub_stage.sv - one carry chunk of the pipelined adder with its stage register and handshake
module addsub_stage
   import adder_pkg::*;
#(
   parameter int CW    = 8,
   parameter int WIDTH = 32,
   parameter bit LAST  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] bx_in,
   input  logic [WIDTH-1:0] sum_in,
   input  logic             carry_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] a_out,
   output logic [WIDTH-1:0] bx_out,
   output logic [WIDTH-1:0] sum_out,
   output logic             carry_out,
   output logic             ovf
);

   logic [CW:0]          chunk;
   logic                 msb_carry_in;
   logic [CW+WIDTH-1:0]  sum_cat;
   logic                 load;
   logic                 unused_low;

   // Operands are pre-shifted so the active chunk is always the low CW bits; finished
   // sum chunks enter at the top and drift down to their final position.
   assign chunk        = {1'b0, a_in[CW-1:0]} + {1'b0, bx_in[CW-1:0]} + {{CW{1'b0}}, carry_in};
   assign msb_carry_in = a_in[CW-1] ^ bx_in[CW-1] ^ chunk[CW-1];
   assign sum_cat      = {chunk[CW-1:0], sum_in};
   assign unused_low   = ^sum_cat[CW-1:0];

   assign in_ready = !out_valid || out_ready;
   assign load     = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         a_out     <= '0;
         bx_out    <= '0;
         sum_out   <= '0;
         carry_out <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         if (in_ready) begin
            out_valid <= in_valid;
         end
         if (load) begin
            a_out     <= a_in >> CW;
            bx_out    <= bx_in >> CW;
            sum_out   <= sum_cat[CW +: WIDTH];
            carry_out <= chunk[CW];
            ovf       <= LAST ? (msb_carry_in ^ chunk[CW]) : 1'b0;
         end
      end
   end

endmodule

// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - pipelined two's-complement adder/subtractor, one carry chunk per stage
module pipelined_addsub
   import adder_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);

   localparam int CW = chunk_width(WIDTH, STAGES);

   if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
      $error("pipelined_addsub: WIDTH must be >= STAGES and a multiple of STAGES");
   end

   logic             valid_chain [STAGES+1];
   logic             ready_chain [STAGES+1];
   logic             carry_chain [STAGES+1];
   logic [WIDTH-1:0] a_chain     [STAGES+1];
   logic [WIDTH-1:0] bx_chain    [STAGES+1];
   logic [WIDTH-1:0] sum_chain   [STAGES+1];
   logic [STAGES-1:0] ovf_stage;
   logic             unused_tail;

   assign valid_chain[0]      = in_valid;
   assign in_ready            = ready_chain[0];
   assign ready_chain[STAGES] = out_ready;
   assign a_chain[0]          = a;
   assign bx_chain[0]         = (sub == OP_ADD) ? b : ~b;
   assign sum_chain[0]        = '0;
   assign carry_chain[0]      = c_in ^ (sub == OP_SUB);

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      addsub_stage #(
         .CW    (CW),
         .WIDTH (WIDTH),
         .LAST  (k == STAGES - 1)
      ) u_stage (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (valid_chain[k]),
         .in_ready  (ready_chain[k]),
         .a_in      (a_chain[k]),
         .bx_in     (bx_chain[k]),
         .sum_in    (sum_chain[k]),
         .carry_in  (carry_chain[k]),
         .out_valid (valid_chain[k+1]),
         .out_ready (ready_chain[k+1]),
         .a_out     (a_chain[k+1]),
         .bx_out    (bx_chain[k+1]),
         .sum_out   (sum_chain[k+1]),
         .carry_out (carry_chain[k+1]),
         .ovf       (ovf_stage[k])
      );
   end

   assign out_valid   = valid_chain[STAGES];
   assign sum         = sum_chain[STAGES];
   assign c_out       = carry_chain[STAGES];
   assign ovf         = ovf_stage[STAGES-1];
   assign unused_tail = ^{a_chain[STAGES], bx_chain[STAGES], ovf_stage};

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - scoreboard bench for pipelined_addsub at 32/4, 8/1 and 64/8
module tb_pipelined_addsub;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] a_drv = '0;
   logic [63:0] b_drv = '0;
   logic        c_in_drv = 1'b0;
   logic        sub_drv = 1'b0;
   logic        iv_drv = 1'b0;
   logic        out_ready_drv = 1'b0;
   int          sel = 0;

   logic [2:0]  iv, ir, ov, co, of;
   logic [31:0] s32;
   logic [7:0]  s8;
   logic [63:0] s64;
   logic        cur_ir, cur_ov, cur_co, cur_of;
   logic [63:0] cur_sum;

   logic [65:0] sb_q [$];
   int          checks = 0;
   int          failures = 0;
   logic        stall_prev = 1'b0;
   logic [65:0] stall_val = '0;

   always #5 clk = ~clk;

   pipelined_addsub #(.WIDTH(32), .STAGES(4)) u_dut32 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a_drv[31:0]), .b(b_drv[31:0]),
      .c_in(c_in_drv), .sub(sub_drv), .out_valid(ov[0]), .out_ready(out_ready_drv),
      .sum(s32), .c_out(co[0]), .ovf(of[0]));

   pipelined_addsub #(.WIDTH(8), .STAGES(1)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a_drv[7:0]), .b(b_drv[7:0]),
      .c_in(c_in_drv), .sub(sub_drv), .out_valid(ov[1]), .out_ready(out_ready_drv),
      .sum(s8), .c_out(co[1]), .ovf(of[1]));

   pipelined_addsub #(.WIDTH(64), .STAGES(8)) u_dut64 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(a_drv), .b(b_drv),
      .c_in(c_in_drv), .sub(sub_drv), .out_valid(ov[2]), .out_ready(out_ready_drv),
      .sum(s64), .c_out(co[2]), .ovf(of[2]));

   always_comb begin
      iv      = 3'b000;
      cur_ir  = ir[0];
      cur_ov  = ov[0];
      cur_co  = co[0];
      cur_of  = of[0];
      cur_sum = {32'd0, s32};
      case (sel)
         1: begin
            iv[1] = iv_drv; cur_ir = ir[1]; cur_ov = ov[1]; cur_co = co[1]; cur_of = of[1];
            cur_sum = {56'd0, s8};
         end
         2: begin
            iv[2] = iv_drv; cur_ir = ir[2]; cur_ov = ov[2]; cur_co = co[2]; cur_of = of[2];
            cur_sum = s64;
         end
         default: iv[0] = iv_drv;
      endcase
   end

   function automatic int get_w(input int s);
      return (s == 1) ? 8 : ((s == 2) ? 64 : 32);
   endfunction

   function automatic int get_stg(input int s);
      return (s == 1) ? 1 : ((s == 2) ? 8 : 4);
   endfunction

   // Reference: plain wide addition, overflow from operand/result sign bits.
   function automatic logic [65:0] model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                         input logic cin, input logic sb);
      logic [63:0] mask, am, bm, s;
      logic [64:0] full;
      logic        cout, ov_s;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      am   = av & mask;
      bm   = (sb ? ~bv : bv) & mask;
      full = {1'b0, am} + {1'b0, bm} + {64'd0, cin ^ sb};
      s    = full[63:0] & mask;
      cout = full[w];
      ov_s = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
      return {ov_s, cout, s};
   endfunction

   always @(negedge clk) begin
      logic [65:0] expv;
      if (rst) begin
         sb_q.delete();
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            checks++;
            if (!cur_ov || ({cur_of, cur_co, cur_sum} !== stall_val)) begin
               failures++;
               $display("FAIL stall_stable got valid=%b val=%h required valid=1 val=%h", cur_ov,
                        {cur_of, cur_co, cur_sum}, stall_val);
            end
         end
         if (cur_ov && out_ready_drv) begin
            checks++;
            if (sb_q.size() == 0) begin
               failures++;
               $display("FAIL sb_unexpected_beat got=%h required=no beat", {cur_of, cur_co, cur_sum});
            end else begin
               expv = sb_q.pop_front();
               if ({cur_of, cur_co, cur_sum} !== expv) begin
                  failures++;
                  $display("FAIL sb_result got=%h required=%h", {cur_of, cur_co, cur_sum}, expv);
               end
            end
         end
         if (iv_drv && cur_ir) begin
            sb_q.push_back(model(get_w(sel), a_drv, b_drv, c_in_drv, sub_drv));
         end
         stall_prev = cur_ov && !out_ready_drv;
         stall_val  = {cur_of, cur_co, cur_sum};
      end
   end

   task automatic set_rand();
      a_drv    = {$urandom, $urandom};
      b_drv    = {$urandom, $urandom};
      c_in_drv = 1'($urandom_range(0, 1));
      sub_drv  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a_drv = '1;
      if ($urandom_range(0, 7) == 0) b_drv = '0;
   endtask

   task automatic single_beat(input logic [63:0] a_v, input logic [63:0] b_v, input logic cin,
                              input logic sb, output int lat, output logic [65:0] res);
      a_drv = a_v; b_drv = b_v; c_in_drv = cin; sub_drv = sb;
      out_ready_drv = 1'b1;
      iv_drv = 1'b1;
      @(posedge clk); #1;
      iv_drv = 1'b0;
      lat = 1;
      while (!cur_ov && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      res = {cur_of, cur_co, cur_sum};
      @(posedge clk); #1;
   endtask

   task automatic drain(input string name);
      int g = 0;
      iv_drv = 1'b0;
      out_ready_drv = 1'b1;
      while ((sb_q.size() != 0 || cur_ov) && g < 200) begin
         @(posedge clk); #1;
         g++;
      end
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL %s_drain got pending=%0d required=0", name, sb_q.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; iv_drv = 1'b0; out_ready_drv = 1'b0; sel = 0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (ir !== 3'b111) begin
         failures++; $display("FAIL reset_in_ready got=%b required=111", ir);
      end
      checks++;
      if (ov !== 3'b000) begin
         failures++; $display("FAIL reset_out_valid got=%b required=000", ov);
      end
      checks++;
      if ({s32, s8, s64, co, of} !== '0) begin
         failures++; $display("FAIL reset_outputs got=%h/%h/%h co=%b ovf=%b required=all zero", s32, s8, s64, co, of);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (ir !== 3'b111 || ov !== 3'b000) begin
         failures++; $display("FAIL post_reset_idle got ready=%b valid=%b required ready=111 valid=000", ir, ov);
      end
   endtask

   task automatic test_ripple(input int dsel);
      int          lat;
      logic [65:0] res;
      sel = dsel;
      single_beat('1, 64'd1, 1'b0, 1'b0, lat, res);
      checks++;
      if (lat != get_stg(dsel)) begin
         failures++; $display("FAIL ripple_latency_w%0d got=%0d required=%0d", get_w(dsel), lat, get_stg(dsel));
      end
      checks++;
      if (res !== {1'b0, 1'b1, 64'd0}) begin
         failures++; $display("FAIL ripple_result_w%0d got=%h required=%h", get_w(dsel), res, {1'b0, 1'b1, 64'd0});
      end
   endtask

   task automatic test_overflow();
      int          lat;
      logic [65:0] res;
      sel = 0;
      single_beat(64'h7FFF_FFFF, 64'd1, 1'b0, 1'b0, lat, res);
      checks++;
      if (res !== {1'b1, 1'b0, 64'h8000_0000}) begin
         failures++; $display("FAIL ovf_add got=%h required=%h", res, {1'b1, 1'b0, 64'h8000_0000});
      end
      single_beat(64'd5, 64'd7, 1'b0, 1'b1, lat, res);
      checks++;
      if (res !== {1'b0, 1'b0, 64'hFFFF_FFFE}) begin
         failures++; $display("FAIL sub_borrow got=%h required=%h", res, {1'b0, 1'b0, 64'hFFFF_FFFE});
      end
      single_beat(64'd5, 64'd7, 1'b1, 1'b1, lat, res);
      checks++;
      if (res !== {1'b0, 1'b0, 64'hFFFF_FFFD}) begin
         failures++; $display("FAIL sub_borrow_in got=%h required=%h", res, {1'b0, 1'b0, 64'hFFFF_FFFD});
      end
   endtask

   task automatic test_stream(input int n, input int dsel);
      int   sent = 0;
      int   guard = 0;
      logic took;
      sel = dsel;
      set_rand();
      iv_drv = 1'b1;
      while (sent < n && guard < 5000) begin
         out_ready_drv = 1'($urandom_range(0, 1));
         #1;
         took = cur_ir;
         @(posedge clk); #1;
         guard++;
         if (took) begin
            sent++;
            if (sent < n) set_rand();
            else iv_drv = 1'b0;
         end
      end
      iv_drv = 1'b0;
      checks++;
      if (sent != n) begin
         failures++; $display("FAIL stream_w%0d_sent got=%0d required=%0d", get_w(dsel), sent, n);
      end
      drain($sformatf("stream_w%0d", get_w(dsel)));
   endtask

   task automatic test_fill();
      int   acc = 0;
      int   both = 0;
      logic took;
      sel = 0;
      out_ready_drv = 1'b0;
      set_rand();
      iv_drv = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         took = cur_ir;
         if (took) acc++;
         @(posedge clk); #1;
         if (took) set_rand();
      end
      checks++;
      if (acc != 4) begin
         failures++; $display("FAIL fill_accepts got=%0d required=4", acc);
      end
      checks++;
      if (cur_ir !== 1'b0) begin
         failures++; $display("FAIL fill_in_ready got=%b required=0", cur_ir);
      end
      out_ready_drv = 1'b1;
      for (int i = 0; i < 12; i++) begin
         #1;
         if (cur_ir && cur_ov) both++;
         @(posedge clk); #1;
         set_rand();
      end
      checks++;
      if (both != 12) begin
         failures++; $display("FAIL full_throughput got=%0d required=12", both);
      end
      drain("fill");
   endtask

   task automatic test_reset_midflight();
      int          lat;
      int          seen = 0;
      logic [65:0] res;
      logic [65:0] expv;
      sel = 0;
      out_ready_drv = 1'b1;
      set_rand();
      iv_drv = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         set_rand();
      end
      iv_drv = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (ov !== 3'b000 || ir !== 3'b111) begin
         failures++; $display("FAIL midflight_reset got valid=%b ready=%b required valid=000 ready=111", ov, ir);
      end
      repeat (8) begin
         @(posedge clk); #1;
         if (cur_ov) seen++;
      end
      checks++;
      if (seen != 0) begin
         failures++; $display("FAIL midflight_stale got=%0d beats required=0", seen);
      end
      expv = model(32, 64'h0000_0000_1234_5678, 64'h0000_0000_8765_4321, 1'b1, 1'b0);
      single_beat(64'h0000_0000_1234_5678, 64'h0000_0000_8765_4321, 1'b1, 1'b0, lat, res);
      checks++;
      if (lat != 4 || res !== expv) begin
         failures++; $display("FAIL midflight_new_beat got lat=%0d res=%h required lat=4 res=%h", lat, res, expv);
      end
   endtask

   initial begin
      test_reset();
      test_ripple(0);
      test_overflow();
      test_stream(100, 0);
      test_fill();
      test_reset_midflight();
      test_ripple(1);
      test_stream(100, 1);
      test_ripple(2);
      test_stream(100, 2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
